// File: rtl/msrv32_param_integer_file_if.sv
// rtl/msrv32_param_integer_file_if.sv - read/write/scoreboard bus of the parametrised integer register file
// master: decode/writeback side; slave: the register file.

interface msrv32_param_integer_file_if #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int NUM_RD = 2
);
  localparam int AW = $clog2(NREGS);

  logic [NUM_RD*AW-1:0]   rs_addr_in;
  logic [NUM_RD*XLEN-1:0] rs_out;
  logic [NUM_RD-1:0]      rs_busy_out;
  logic                   wr_en_in;
  logic [AW-1:0]          rd_addr_in;
  logic [XLEN-1:0]        rd_in;
  logic                   mark_en_in;
  logic [AW-1:0]          mark_addr_in;
  logic [NREGS-1:0]       busy_vec_out;

  modport master (
    output rs_addr_in, wr_en_in, rd_addr_in, rd_in, mark_en_in, mark_addr_in,
    input  rs_out, rs_busy_out, busy_vec_out
  );

  modport slave (
    input  rs_addr_in, wr_en_in, rd_addr_in, rd_in, mark_en_in, mark_addr_in,
    output rs_out, rs_busy_out, busy_vec_out
  );
endinterface

// File: rtl/msrv32_param_integer_file.sv
// rtl/msrv32_param_integer_file.sv - parametrised integer register file with per-register busy scoreboard
// Optional MSRV32_RF_WR_FWD_EN: same-cycle write-through forwarding onto the read ports.

module msrv32_param_integer_file #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int NUM_RD = 2
) (
  input  logic                        ms_riscv32_mp_clk_in,
  input  logic                        ms_riscv32_mp_rst_in,
  msrv32_param_integer_file_if.slave  rf_bus
);
  localparam int AW = $clog2(NREGS);

  logic [XLEN-1:0]        regs [NREGS];
  logic [NREGS-1:0]       busy_q;
  logic [NREGS-1:0]       busy_nxt;
  logic                   wr_valid;
  logic                   mark_valid;
  logic [AW-1:0]          port_addr [NUM_RD];
  logic                   port_hit  [NUM_RD];
  logic [NUM_RD*XLEN-1:0] rs_data;
  logic [NUM_RD-1:0]      rs_busy;

  assign wr_valid   = rf_bus.wr_en_in   && (rf_bus.rd_addr_in   != '0);
  assign mark_valid = rf_bus.mark_en_in && (rf_bus.mark_addr_in != '0);

  // Mark is applied after the clear so a same-register mark+write leaves it busy.
  always_comb begin
    busy_nxt = busy_q;
    if (wr_valid)
      busy_nxt[rf_bus.rd_addr_in] = 1'b0;
    if (mark_valid)
      busy_nxt[rf_bus.mark_addr_in] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (ms_riscv32_mp_rst_in) begin
      for (int i = 0; i < NREGS; i++)
        regs[i] <= '0;
      busy_q <= '0;
    end else begin
      if (wr_valid)
        regs[rf_bus.rd_addr_in] <= rf_bus.rd_in;
      busy_q <= busy_nxt;
    end
  end

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    assign port_addr[g] = rf_bus.rs_addr_in[g*AW +: AW];
`ifdef MSRV32_RF_WR_FWD_EN
    assign port_hit[g]  = wr_valid && (rf_bus.rd_addr_in == port_addr[g]);
`else
    assign port_hit[g]  = 1'b0;
`endif
  end

  // Entry 0 is gated here, so its storage is never observable.
  always_comb begin
    rs_data = '0;
    rs_busy = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      if (port_hit[i]) begin
        rs_data[i*XLEN +: XLEN] = rf_bus.rd_in;
        rs_busy[i]              = 1'b0;
      end else if (port_addr[i] != '0) begin
        rs_data[i*XLEN +: XLEN] = regs[port_addr[i]];
        rs_busy[i]              = busy_q[port_addr[i]];
      end
    end
  end

  assign rf_bus.rs_out       = rs_data;
  assign rf_bus.rs_busy_out  = rs_busy;
  assign rf_bus.busy_vec_out = busy_q;

endmodule

// File: doc/msrv32_param_integer_file.md
Name: msrv32_param_integer_file

Overview:
Parametrised successor to the fixed 32x32 integer register file. It is generalised in data width, register count and number of read ports. It adds a per-register busy scoreboard so the decode stage can detect RAW hazards on registers whose producer is still in flight. It sits between decode (read ports, busy marking) and writeback (write port) in the msrv32 pipeline.

Parameters:
XLEN, 32, data width of each register in bits (8..64).
NREGS, 32, number of architectural registers; power of two, 2..64; register 0 is hardwired zero.
NUM_RD, 2, number of independent read ports (1..4).
AW, clog2(NREGS), address width; derived, not overridden.

Ports:
ms_riscv32_mp_clk_in  input  1  single clock; all state updates on the rising edge.
ms_riscv32_mp_rst_in  input  1  synchronous, active-high reset.
rs_addr_in  input  NUM_RD*AW  packed read addresses; port i is [i*AW +: AW].
rs_out  output  NUM_RD*XLEN  packed read data; port i is [i*XLEN +: XLEN].
rs_busy_out  output  NUM_RD  bit i = busy flag of the register addressed by port i.
wr_en_in  input  1  writeback write enable.
rd_addr_in  input  AW  writeback destination address.
rd_in  input  XLEN  writeback data.
mark_en_in  input  1  issue-side request to set a busy flag.
mark_addr_in  input  AW  register to mark busy.
busy_vec_out  output  NREGS  full scoreboard; bit 0 is always 0.

Behaviour:
- State: reg array NREGS x XLEN and busy vector NREGS bits. Entry 0 is not stored and reads as 0.
- Reset: on a rising edge with rst=1, all registers are cleared to 0 and all busy bits are cleared. Reset takes precedence over a simultaneous write or mark.
- Post-reset outputs: rs_out = 0 on every port, rs_busy_out = 0, busy_vec_out = 0.
- Reads are combinational/asynchronous with zero latency.
  - rs_out[i] = reg[rs_addr_i]; 0 when rs_addr_i == 0.
  - rs_busy_out[i] = busy[rs_addr_i]; 0 when rs_addr_i == 0.
- Write: on a rising edge with wr_en_in=1, rst=0 and rd_addr_in != 0, reg[rd_addr_in] <= rd_in. The new value is visible on the reads in the next cycle.
- Write to address 0 is silently dropped; no state changes.
- Busy update per edge (rst=0), in priority order:
  1. mark_en_in=1 and mark_addr != 0 -> busy[mark_addr] <= 1.
  2. Otherwise, wr_en_in=1 and rd_addr != 0 -> busy[rd_addr] <= 0.
  - Mark and write on the same edge to different registers: both take effect.
  - Mark and write on the same edge to the same register: data is written and busy ends at 1, because a new producer has issued.
- Writing a register that is not busy is legal; data is updated and busy stays 0.
- Marking an already-busy register is legal; busy stays 1.
- All read ports are independent. Identical addresses on several ports return identical data.
- No internal FSM beyond the scoreboard; there are no stalls and no handshake back-pressure.

Optional Feature:
Macro MSRV32_RF_WR_FWD_EN.
- Defined: write-through forwarding. For each port i, when wr_en_in=1, rd_addr_in != 0 and rd_addr_in == rs_addr_i, then rs_out[i] = rd_in and rs_busy_out[i] = 0 in that same cycle.
  - This holds even if a mark to the same address is present; the mark affects the next cycle only.
  - busy_vec_out is not forwarded; it always shows the registered state.
- Undefined: reads during a write return the old stored value and the registered busy bit; the new value appears the following cycle.

Test Plan:
1. Reset with defaults, then hold rst=1 while wr_en_in=1, rd_addr=5, rd_in=32'hDEADBEEF for one edge -> after deassert, port0 addr 5 reads 0 and busy_vec_out=0.
2. Write 32'hA5A5A5A5 to r1, then 32'h5A5A5A5A to r2; set port0=1, port1=2 -> rs_out = {32'h5A5A5A5A, 32'hA5A5A5A5}. Then write 32'hFFFFFFFF to r0 and read r0 on both ports -> 0.
3. Scoreboard: mark r3 -> rs_busy_out for addr 3 = 1 and busy_vec_out=32'h8. Next, write r3=32'h12345678 -> busy clears to 0 and r3 reads 32'h12345678. Mark r0 -> busy_vec_out stays 0.
4. Same-edge mark and write of r6 with 32'hF0F0F0F0 -> r6 reads F0F0F0F0 and busy[6]=1. Same-edge mark r7 and write r8 -> busy[7]=1 and busy[8]=0.
5. Forwarding: write r9=32'h11111111 in an earlier cycle. In the next cycle, write r9=32'hCAFEF00D while port0 reads r9 in that same cycle.
   - With MSRV32_RF_WR_FWD_EN: rs_out port0 = CAFEF00D in that cycle.
   - Without it: rs_out port0 = 11111111 in that cycle, then CAFEF00D in the next.
6. Parameter sweep XLEN=16, NREGS=8, NUM_RD=3: write r7=16'hBEEF and read it on all three ports -> each returns BEEF. Mark r7, then apply reset -> busy_vec_out=8'h00 and r7 reads 0.
